// File: rtl/caxi4interconnect_strb_merge_fifo.sv
// rtl/caxi4interconnect_strb_merge_fifo.sv - byte-strobed FIFO with tail-merge writes, occupancy flags and sticky ovf/udf (optional FIFO_PARITY_EN)
module caxi4interconnect_strb_merge_fifo #(
  parameter int FIFO_AWIDTH  = 4,
  parameter int FIFO_WIDTH   = 32,
  parameter int AFULL_THRESH = 12
) (
  input  logic                    HCLK,
  input  logic                    sysReset,
  input  logic                    fifoWrite,
  input  logic                    fifoWrMerge,
  input  logic [FIFO_WIDTH/8-1:0] fifoWrStrb,
  input  logic [FIFO_WIDTH-1:0]   fifoWrData,
  input  logic                    fifoRead,
  output logic [FIFO_WIDTH-1:0]   fifoRdData,
  output logic                    fifoRdValid,
  output logic                    fifoFull,
  output logic                    fifoEmpty,
  output logic                    fifoAFull,
  output logic [FIFO_AWIDTH:0]    fifoCount,
`ifdef FIFO_PARITY_EN
  output logic                    fifoParErr,
`endif
  output logic                    fifoOvf,
  output logic                    fifoUdf
);

  localparam int DEPTH = 1 << FIFO_AWIDTH;
  localparam int NLANE = FIFO_WIDTH / 8;
  localparam int CW    = FIFO_AWIDTH + 1;

  logic [FIFO_WIDTH-1:0]  r_mem [DEPTH];
  logic [FIFO_AWIDTH-1:0] r_wr_ptr;
  logic [FIFO_AWIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic                   r_empty;
  logic                   r_full;
  logic                   r_afull;
  logic                   r_rd_valid;
  logic [FIFO_WIDTH-1:0]  r_rd_data;
  logic                   r_ovf;
  logic                   r_udf;

  logic                   w_pop_acc;
  logic                   w_eff_merge;
  logic                   w_push_req;
  logic                   w_push_acc;
  logic [CW-1:0]          w_count_nxt;
  logic [FIFO_AWIDTH-1:0] w_wr_addr;
  logic [NLANE-1:0]       w_lane_we;
  logic [FIFO_WIDTH-1:0]  w_lane_data;

  // Request qualification: a merge only lands on a tail that survives this cycle's pop
  always_comb begin
    w_pop_acc   = fifoRead & ~r_empty;
    w_eff_merge = fifoWrite & fifoWrMerge & (r_count != '0)
                  & ~((r_count == CW'(1)) & w_pop_acc);
    w_push_req  = fifoWrite & ~w_eff_merge;
    w_push_acc  = w_push_req & ~r_full;
  end

  // Next occupancy from accepted push/pop
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_acc, w_pop_acc})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Lane enables: a push rewrites every lane (unstrobed lanes become 0), a merge only strobed lanes
  always_comb begin
    w_wr_addr = w_eff_merge ? (r_wr_ptr - FIFO_AWIDTH'(1)) : r_wr_ptr;
    for (int i = 0; i < NLANE; i++) begin
      w_lane_we[i]         = ~sysReset & (w_push_acc | (w_eff_merge & fifoWrStrb[i]));
      w_lane_data[i*8 +: 8] = fifoWrStrb[i] ? fifoWrData[i*8 +: 8] : 8'h00;
    end
  end

  // Array write port (contents intentionally not reset)
  always_ff @(posedge HCLK) begin
    for (int i = 0; i < NLANE; i++) begin
      if (w_lane_we[i]) r_mem[w_wr_addr][i*8 +: 8] <= w_lane_data[i*8 +: 8];
    end
  end

  // Pointers, occupancy, registered flags and read port
  always_ff @(posedge HCLK) begin
    if (sysReset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_afull    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + FIFO_AWIDTH'(1);
      if (w_pop_acc) begin
        r_rd_ptr  <= r_rd_ptr + FIFO_AWIDTH'(1);
        r_rd_data <= r_mem[r_rd_ptr];
      end
      r_rd_valid <= w_pop_acc;
      r_count    <= w_count_nxt;
      r_empty    <= (w_count_nxt == '0);
      r_full     <= (w_count_nxt == CW'(DEPTH));
      r_afull    <= (w_count_nxt >= CW'(AFULL_THRESH));
      if (w_push_req & r_full)  r_ovf <= 1'b1;
      if (fifoRead & r_empty)   r_udf <= 1'b1;
    end
  end

`ifdef FIFO_PARITY_EN
  logic [NLANE-1:0] r_par_mem [DEPTH];
  logic [NLANE-1:0] r_rd_par;
  logic [NLANE-1:0] w_wr_par;
  logic [NLANE-1:0] w_rd_par_calc;

  // Even parity per lane of the final stored byte (only written lanes change)
  always_comb begin
    for (int i = 0; i < NLANE; i++) begin
      w_wr_par[i]      = ^w_lane_data[i*8 +: 8];
      w_rd_par_calc[i] = ^r_rd_data[i*8 +: 8];
    end
  end

  // Parity array write port
  always_ff @(posedge HCLK) begin
    for (int i = 0; i < NLANE; i++) begin
      if (w_lane_we[i]) r_par_mem[w_wr_addr][i] <= w_wr_par[i];
    end
  end

  // Stored parity travels with the popped data
  always_ff @(posedge HCLK) begin
    if (sysReset) r_rd_par <= '0;
    else if (w_pop_acc) r_rd_par <= r_par_mem[r_rd_ptr];
  end

  assign fifoParErr = r_rd_valid & (|(w_rd_par_calc ^ r_rd_par));
`endif

  assign fifoRdData  = r_rd_data;
  assign fifoRdValid = r_rd_valid;
  assign fifoFull    = r_full;
  assign fifoEmpty   = r_empty;
  assign fifoAFull   = r_afull;
  assign fifoCount   = r_count;
  assign fifoOvf     = r_ovf;
  assign fifoUdf     = r_udf;

endmodule
